// File: rtl/pipe_drain_fifo.sv
// Output buffer behind the last pipeline stage: absorbs consumer stalls so the
// pipeline only sees back-pressure once DEPTH words are queued.
module pipe_drain_fifo #(
  parameter int WIDTH = 100,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_allowin,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pipe_drain_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             full, empty, push, pop;

  // count alone decides full/empty, so pointers can wrap without a lap bit
  assign full       = (cnt == FULL_CNT);
  assign empty      = (cnt == '0);
  assign in_allowin = !full && !flush;
  assign push       = in_valid && in_allowin;
  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready && !flush;
  assign out_data   = mem[rd_ptr];
  assign count      = cnt;

  // storage is deliberately left out of reset and flush
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_drain_fifo.sv
// Bench for pipe_drain_fifo: directed scenarios plus random traffic, all
// checked against a queue model of the buffer.
module tb_pipe_drain_fifo;
  localparam int WIDTH = 100;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_allowin;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic [CW-1:0]    count;

  int vectors = 0;
  int errs    = 0;
  bit chk_en  = 1'b0;
  bit last_push = 1'b0;
  logic [WIDTH-1:0] q[$];

  pipe_drain_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_allowin(in_allowin),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO queue; flush empties it, otherwise pop then push.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      last_push = 1'b0;
    end else if (flush) begin
      q.delete();
      last_push = 1'b0;
    end else begin
      bit do_push, do_pop;
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && out_ready;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(in_data);
      last_push = do_push;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 128'(count), 128'(q.size()));
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("in_allowin", 128'(in_allowin), 128'((q.size() < DEPTH) && !flush));
      if (q.size() != 0) chk("out_data", 128'(out_data), 128'(q[0]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset dropped mid-cycle, outputs must respond without a clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("rst_count", 128'(count), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_allowin", 128'(in_allowin), 128'd1);
    step(); step();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // fill with consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      step();
      chk("fill_count", 128'(count), 128'(i));
    end
    chk("full_allowin", 128'(in_allowin), 128'd0);
    in_data = WIDTH'(5);
    step();
    chk("full_hold_count", 128'(count), 128'd4);

    // drain; held 0x5 slips in after the first pop
    out_ready = 1'b1;
    chk("drain_d0", 128'(out_data), 128'h1);
    step(); chk("drain_d1", 128'(out_data), 128'h2); chk("drain_c1", 128'(count), 128'd3);
    step(); chk("drain_d2", 128'(out_data), 128'h3); chk("drain_c2", 128'(count), 128'd3);
    in_valid = 1'b0;
    step(); chk("drain_d3", 128'(out_data), 128'h4);
    step(); chk("drain_d4", 128'(out_data), 128'h5); chk("drain_c4", 128'(count), 128'd1);
    step(); chk("drain_empty", 128'(out_valid), 128'd0);

    // steady push+pop at count 2
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = WIDTH'('h10); step();
    in_data = WIDTH'('h11); step();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_data = WIDTH'('h11 + k);
      step();
      chk("pp_count", 128'(count), 128'd2);
      chk("pp_data", 128'(out_data), 128'('h10 + k));
    end
    in_valid = 1'b0;
    step(); step();
    chk("pp_drained", 128'(out_valid), 128'd0);

    // flush with count 3 and both handshakes active
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = WIDTH'('h20 + i); step();
    end
    chk("pre_flush_count", 128'(count), 128'd3);
    flush = 1'b1; in_data = WIDTH'('h99); out_ready = 1'b1;
    #1 chk("flush_allowin", 128'(in_allowin), 128'd0);
    step();
    flush = 1'b0;
    chk("flush_count", 128'(count), 128'd0);
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_data = WIDTH'('hA);
    step();
    in_valid = 1'b0;
    chk("post_flush_data", 128'(out_data), 128'hA);

    // async reset with count 2 and traffic flowing
    in_valid = 1'b1; in_data = WIDTH'('hB); step();
    chk("pre_rst_count", 128'(count), 128'd2);
    in_data = WIDTH'('hC); out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 128'(count), 128'd0);
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    step();
    rst_n = 1'b1;
    in_data = WIDTH'('hD); out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("post_rst_data", 128'(out_data), 128'hD);
    chk("post_rst_count", 128'(count), 128'd1);

    // random traffic; upstream holds a refused word stable
    for (int n = 0; n < 3000; n++) begin
      if (!(in_valid && !last_push)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 2) != 0) ^ (n[9] & n[8]);
      flush     = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
